// File: rtl/fpu_pkg.sv
// Shared FPU constants, state encodings and operand classification helpers.
package fpu_pkg;

  localparam int         EXP_BIAS = 127;
  localparam logic [7:0] EXP_MAX  = 8'hFF;
  localparam int         MANT_W   = 23;

  // Divider sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_NORM = 2'd2,
    ST_DONE = 2'd3
  } fdiv_state_t;

  // Outcome class of a division, decided once when the operands are taken
  typedef enum logic [1:0] {
    SP_NONE   = 2'd0,  // ordinary operands, run the mantissa divider
    SP_ZERO   = 2'd1,  // result is signed zero
    SP_INF    = 2'd2,  // result is signed infinity
    SP_INF_DZ = 2'd3   // result is signed infinity, flag divide-by-zero
  } fdiv_special_t;

  // Classify operands by exponent only; first matching rule wins so 0/0 gives zero
  function automatic fdiv_special_t fdiv_classify(input logic [7:0] e1, input logic [7:0] e2);
    fdiv_special_t sp;
    if (e1 == 8'd0) begin
      sp = SP_ZERO;
    end else if (e2 == 8'd0) begin
      sp = SP_INF_DZ;
    end else if (e1 == EXP_MAX) begin
      sp = SP_INF;
    end else if (e2 == EXP_MAX) begin
      sp = SP_ZERO;
    end else begin
      sp = SP_NONE;
    end
    return sp;
  endfunction

endpackage

// File: rtl/fdiv_step.sv
// One restoring-division step: compare partial remainder with the divisor,
// subtract when it fits, and shift left for the next quotient bit.
module fdiv_step (
  input  logic [24:0] i_r,
  input  logic [23:0] i_mb,
  output logic [24:0] o_r,
  output logic        o_q
);

  logic        w_ge;
  logic [23:0] w_diff;

  // The remainder always stays below 2*mb, so r-mb fits in 24 bits when r >= mb
  always_comb begin
    w_ge   = (i_r >= {1'b0, i_mb});
    w_diff = i_r[23:0] - i_mb;
    if (w_ge) begin
      o_q = 1'b1;
      o_r = {w_diff, 1'b0};
    end else begin
      o_q = 1'b0;
      o_r = {i_r[23:0], 1'b0};
    end
  end

endmodule

// File: rtl/fdiv_seq.sv
// Iterative binary32 divider y = x1 / x2: one quotient bit per cycle,
// truncating rounding, denormal inputs and results flushed to zero.
module fdiv_seq
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] y,
  output logic        ovf,
  output logic        dz,
  output logic        out_valid,
  input  logic        out_ready
);

  fdiv_state_t          r_state;
  fdiv_special_t        r_special;
  logic                 r_s;
  logic signed [9:0]    r_ye0;
  logic [23:0]          r_mb;
  logic [24:0]          r_r;
  logic [24:0]          r_q;
  logic [4:0]           r_cnt;
  logic [31:0]          r_y;
  logic                 r_ovf;
  logic                 r_dz;
  logic                 r_out_valid;

  logic [7:0]           w_e1;
  logic [7:0]           w_e2;
  fdiv_special_t        w_special_in;
  logic [24:0]          w_step_r;
  logic                 w_step_q;
  logic signed [9:0]    w_ye;
  logic [MANT_W-1:0]    w_mant;
  logic [31:0]          w_norm_y;
  logic                 w_norm_ovf;
  logic                 w_norm_dz;

  assign w_e1         = x1[30:23];
  assign w_e2         = x2[30:23];
  assign w_special_in = fdiv_classify(w_e1, w_e2);

  assign in_ready  = (r_state == ST_IDLE) && rstn;
  assign y         = r_y;
  assign ovf       = r_ovf;
  assign dz        = r_dz;
  assign out_valid = r_out_valid;

  fdiv_step u_step (
    .i_r  (r_r),
    .i_mb (r_mb),
    .o_r  (w_step_r),
    .o_q  (w_step_q)
  );

  // Normalise the quotient, apply exponent range limits and the special outcomes
  always_comb begin
    w_ye       = r_ye0;
    w_mant     = r_q[22:0];
    w_norm_y   = {r_s, 31'd0};
    w_norm_ovf = 1'b0;
    w_norm_dz  = 1'b0;
    if (r_q[24]) begin
      w_mant = r_q[23:1];
      w_ye   = r_ye0;
    end else begin
      w_mant = r_q[22:0];
      w_ye   = r_ye0 - 10'sd1;
    end
    case (r_special)
      SP_NONE: begin
        if (!w_ye[9] && (w_ye >= 10'sd255)) begin
          w_norm_y   = {r_s, EXP_MAX, 23'd0};
          w_norm_ovf = 1'b1;
        end else if (w_ye[9] || (w_ye == 10'sd0)) begin
          w_norm_y = {r_s, 31'd0};
        end else begin
          w_norm_y = {r_s, w_ye[7:0], w_mant};
        end
      end
      SP_ZERO: begin
        w_norm_y = {r_s, 31'd0};
      end
      SP_INF: begin
        w_norm_y = {r_s, EXP_MAX, 23'd0};
      end
      SP_INF_DZ: begin
        w_norm_y  = {r_s, EXP_MAX, 23'd0};
        w_norm_dz = 1'b1;
      end
      default: begin
        w_norm_y = {r_s, 31'd0};
      end
    endcase
  end

  // Sequencer: capture operands, iterate the mantissa divider, publish and hold result
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_special   <= SP_NONE;
      r_s         <= 1'b0;
      r_ye0       <= 10'sd0;
      r_mb        <= 24'd0;
      r_r         <= 25'd0;
      r_q         <= 25'd0;
      r_cnt       <= 5'd0;
      r_y         <= 32'd0;
      r_ovf       <= 1'b0;
      r_dz        <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_special <= w_special_in;
            r_s       <= x1[31] ^ x2[31];
            r_ye0     <= {2'b00, w_e1} - {2'b00, w_e2} + 10'(EXP_BIAS);
            r_mb      <= {1'b1, x2[22:0]};
            r_r       <= {2'b01, x1[22:0]};
            r_q       <= 25'd0;
            r_cnt     <= 5'd24;
            r_ovf     <= 1'b0;
            r_dz      <= 1'b0;
            if (w_special_in == SP_NONE) begin
              r_state <= ST_CALC;
            end else begin
              r_state <= ST_NORM;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          r_r          <= w_step_r;
          r_q[r_cnt]   <= w_step_q;
          r_cnt        <= r_cnt - 5'd1;
          if (r_cnt == 5'd0) begin
            r_state <= ST_NORM;
          end else begin
            r_state <= ST_CALC;
          end
        end
        ST_NORM: begin
          r_y         <= w_norm_y;
          r_ovf       <= w_norm_ovf;
          r_dz        <= w_norm_dz;
          r_out_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
